clock_sequencer: RTL and testbench

Generates the three machine-cycle phase clocks (ctrl_clk, read_clk, write_clk) and the stretched system reset for the primary control unit and the bus modules, all derived from one master clock. It provides free-run, single-step and halt-on-stop-clock operation, plus a completed-machine-cycle counter for the front panel and for debug.

---
 rtl/clock_sequencer.sv | 126 ++++++++++++
 tb/tb_clock_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_sequencer.sv
// rtl/clock_sequencer.sv - machine-cycle phase clock generator with stretched system reset
// Emits ctrl/read/write phase pulses, supports free-run, single-step and stop-clock halt.
module clock_sequencer #(
  parameter int GAP_CYCLES    = 1,
  parameter int RESET_STRETCH = 4,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt_req,
  output logic                   ctrl_clk,
  output logic                   read_clk,
  output logic                   write_clk,
  output logic                   sys_reset,
  output logic                   running,
  output logic                   stopped,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_HALTED   = 3'd1;
  localparam logic [2:0] ST_CTRL     = 3'd2;
  localparam logic [2:0] ST_READ     = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  localparam int SW = $clog2(RESET_STRETCH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RESET_STRETCH - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [SW-1:0] stretch_cnt;
  logic [GW-1:0] gap_cnt;
  logic          run_q;
  logic          step_mode;
  logic          halt_latched;
  logic          start;

  // A run rising edge restarts even after a stop-clock halt; a steady run level does not.
  assign start = step | (run & ~stopped) | (run & ~run_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RST_HOLD;
      stretch_cnt  <= '0;
      gap_cnt      <= '0;
      run_q        <= 1'b0;
      step_mode    <= 1'b0;
      halt_latched <= 1'b0;
      ctrl_clk     <= 1'b0;
      read_clk     <= 1'b0;
      write_clk    <= 1'b0;
      sys_reset    <= 1'b1;
      running      <= 1'b0;
      stopped      <= 1'b0;
      cycle_count  <= '0;
    end else begin
      run_q <= run;
      case (state)
        ST_RST_HOLD: begin
          if (stretch_cnt == STRETCH_LAST) begin
            sys_reset <= 1'b0;
            state     <= ST_HALTED;
          end else begin
            stretch_cnt <= stretch_cnt + SW'(1);
          end
        end
        ST_HALTED: begin
          if (start) begin
            state     <= ST_CTRL;
            ctrl_clk  <= 1'b1;
            running   <= 1'b1;
            stopped   <= 1'b0;
            step_mode <= ~run;
          end
        end
        ST_CTRL: begin
          ctrl_clk <= 1'b0;
          read_clk <= 1'b1;
          state    <= ST_READ;
        end
        ST_READ: begin
          read_clk  <= 1'b0;
          write_clk <= 1'b1;
          state     <= ST_WRITE;
          if (halt_req) halt_latched <= 1'b1;
        end
        ST_WRITE: begin
          write_clk   <= 1'b0;
          gap_cnt     <= '0;
          state       <= ST_GAP;
          cycle_count <= cycle_count + COUNT_WIDTH'(1);
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (halt_latched) begin
              state        <= ST_HALTED;
              running      <= 1'b0;
              stopped      <= 1'b1;
              halt_latched <= 1'b0;
            end else if (step_mode || !run) begin
              state   <= ST_HALTED;
              running <= 1'b0;
            end else begin
              state    <= ST_CTRL;
              ctrl_clk <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state     <= ST_HALTED;
          ctrl_clk  <= 1'b0;
          read_clk  <= 1'b0;
          write_clk <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_sequencer.sv
// tb/tb_clock_sequencer.sv - self-checking bench for clock_sequencer
// Slot-position model compared every negedge, plus literal spot checks.
module tb_clock_sequencer;

  localparam int GAP   = 1;
  localparam int STR   = 4;
  localparam int CW    = 4;
  localparam int CYC   = 3 + GAP;
  localparam int MODV  = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt_req = 1'b0;
  logic          ctrl_clk, read_clk, write_clk, sys_reset, running, stopped;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  clock_sequencer #(.GAP_CYCLES(GAP), .RESET_STRETCH(STR), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .ctrl_clk(ctrl_clk), .read_clk(read_clk), .write_clk(write_clk),
    .sys_reset(sys_reset), .running(running), .stopped(stopped),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot is the position inside the current machine cycle, -1 when idle.
  int hold_left;
  int slot;
  int m_count;
  bit m_sysrst, m_stopped, m_halt, m_step, m_runq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_left = STR;
      slot      = -1;
      m_count   = 0;
      m_sysrst  = 1;
      m_stopped = 0;
      m_halt    = 0;
      m_step    = 0;
      m_runq    = 0;
    end else begin
      bit old_runq;
      old_runq = m_runq;
      m_runq   = run;
      if (m_sysrst) begin
        hold_left--;
        if (hold_left == 0) m_sysrst = 0;
      end else if (slot < 0) begin
        if (step || (run && !m_stopped) || (run && !old_runq)) begin
          slot      = 0;
          m_stopped = 0;
          m_step    = !run;
        end
      end else begin
        if (slot == 1 && halt_req) m_halt = 1;
        if (slot == 2) m_count = (m_count + 1) % MODV;
        if (slot == CYC - 1) begin
          if (m_halt) begin
            slot = -1; m_stopped = 1; m_halt = 0;
          end else if (m_step || !run) begin
            slot = -1;
          end else begin
            slot = 0;
          end
        end else begin
          slot++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ctrl_clk",    int'(ctrl_clk),    int'(slot == 0));
    check("read_clk",    int'(read_clk),    int'(slot == 1));
    check("write_clk",   int'(write_clk),   int'(slot == 2));
    check("running",     int'(running),     int'(slot >= 0));
    check("sys_reset",   int'(sys_reset),   int'(m_sysrst));
    check("stopped",     int'(stopped),     int'(m_stopped));
    check("cycle_count", int'(cycle_count), m_count);
    check("one_phase",   int'(ctrl_clk) + int'(read_clk) + int'(write_clk) <= 1 ? 1 : 0, 1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    check("rst_ctrl_low", int'(ctrl_clk), 0);
    reset = 1'b0;

    // Reset stretch: high for 4 edges after release.
    tick(3);
    check("stretch_3", int'(sys_reset), 1);
    tick(1);
    check("stretch_4", int'(sys_reset), 0);
    check("count_after_rst", int'(cycle_count), 0);

    // Free-run: period 4, five cycles after 20 clk.
    run = 1'b1;
    tick(1);
    check("fr_first_ctrl", int'(ctrl_clk), 1);
    tick(19);
    check("fr_count_5", int'(cycle_count), 5);
    check("fr_in_gap", int'(running), 1);
    run = 1'b0;
    tick(1);
    check("fr_halted", int'(running), 0);

    // Single step, with a second step during the cycle ignored.
    step = 1'b1;
    tick(1);
    check("step_ctrl", int'(ctrl_clk), 1);
    step = 1'b0;
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(4);
    check("step_count", int'(cycle_count), 6);
    check("step_idle", int'(running), 0);

    // Halt during READ.
    run = 1'b1;
    tick(2);
    check("halt_in_read", int'(read_clk), 1);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(2);
    check("halt_stopped", int'(stopped), 1);
    check("halt_count", int'(cycle_count), 7);
    tick(10);
    check("halt_holds", int'(running), 0);
    run = 1'b0;
    tick(1);
    run = 1'b1;
    tick(1);
    check("restart_ctrl", int'(ctrl_clk), 1);
    check("restart_unstop", int'(stopped), 0);

    // halt_req outside READ is ignored.
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(1);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    tick(1);
    check("ignore_halt_ctrl", int'(ctrl_clk), 1);
    check("ignore_halt_stop", int'(stopped), 0);

    // Async reset during WRITE.
    tick(2);
    check("pre_rst_write", int'(write_clk), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_write_low", int'(write_clk), 0);
    check("async_count_0", int'(cycle_count), 0);
    check("async_sysrst", int'(sys_reset), 1);
    tick(3);
    reset = 1'b0;
    tick(3);
    check("r2_stretch_3", int'(sys_reset), 1);
    tick(1);
    check("r2_stretch_4", int'(sys_reset), 0);
    check("r2_halted", int'(running), 0);
    tick(1);
    check("r2_run_start", int'(ctrl_clk), 1);

    // Counter wrap at 2^4.
    tick(60);
    check("wrap_15", int'(cycle_count), 15);
    tick(4);
    check("wrap_0", int'(cycle_count), 0);

    run = 1'b0;
    tick(6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
